// File: rtl/led_frame_sequencer_if.sv
// Byte-writer handshake bundle between the LED frame sequencer and the SPI byte writer.
// The sequencer drives start/byte; the writer answers with busy.
interface led_frame_sequencer_if;
    logic       spi_start;
    logic [7:0] spi_byte;
    logic       spi_busy;

    modport master (output spi_start, output spi_byte, input spi_busy);
    modport slave  (input spi_start, input spi_byte, output spi_busy);
endinterface

// File: rtl/led_frame_sequencer.sv
// Walks pixel memory and streams one APA102-style frame (start, per-LED, end bytes)
// to the SPI byte writer, one byte in flight at a time.
module led_frame_sequencer #(
    parameter int unsigned NUM_LEDS    = 60,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned START_BYTES = 4,
    parameter int unsigned END_BYTES   = 4
) (
    input  logic                     i_spi_clk,
    input  logic                     i_reset_n,
    input  logic                     i_frame_start,
    input  logic [4:0]               i_brightness,
    output logic                     o_frame_busy,
    output logic                     o_frame_done,
    output logic [ADDR_W-1:0]        o_pix_addr,
    input  logic [23:0]              i_pix_data,
    led_frame_sequencer_if.master    spi
);

    localparam int unsigned CNT_MAX = (START_BYTES > END_BYTES) ? START_BYTES : END_BYTES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_FETCH, S_HDR, S_BLU, S_GRN, S_RED, S_EOF
    } state_t;

    typedef enum logic [1:0] {BH_IDLE, BH_REQ, BH_ACK} bh_t;

    state_t              r_state, w_state_n;
    bh_t                 r_bh, w_bh_n;
    logic [ADDR_W-1:0]   r_led_cnt, w_led_cnt_n;
    logic [CNT_W-1:0]    r_byte_cnt, w_byte_cnt_n;
    logic [4:0]          r_bright, w_bright_n;
    logic [23:0]         r_pix, w_pix_n;
    logic                r_fetch_wait, w_fetch_wait_n;
    logic                r_frame_busy, w_frame_busy_n;
    logic                r_frame_done, w_frame_done_n;
    logic [ADDR_W-1:0]   r_pix_addr, w_pix_addr_n;
    logic                r_spi_start, w_spi_start_n;
    logic [7:0]          r_spi_byte, w_spi_byte_n;
    logic                w_send_c;
    logic                w_byte_done_c;
    logic [7:0]          w_tx_byte_c;

    assign o_frame_busy  = r_frame_busy;
    assign o_frame_done  = r_frame_done;
    assign o_pix_addr    = r_pix_addr;
    assign spi.spi_start = r_spi_start;
    assign spi.spi_byte  = r_spi_byte;

    // State and output registers
    always_ff @(posedge i_spi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_bh         <= BH_IDLE;
            r_led_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_bright     <= '0;
            r_pix        <= '0;
            r_fetch_wait <= 1'b0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_pix_addr   <= '0;
            r_spi_start  <= 1'b0;
            r_spi_byte   <= '0;
        end else begin
            r_state      <= w_state_n;
            r_bh         <= w_bh_n;
            r_led_cnt    <= w_led_cnt_n;
            r_byte_cnt   <= w_byte_cnt_n;
            r_bright     <= w_bright_n;
            r_pix        <= w_pix_n;
            r_fetch_wait <= w_fetch_wait_n;
            r_frame_busy <= w_frame_busy_n;
            r_frame_done <= w_frame_done_n;
            r_pix_addr   <= w_pix_addr_n;
            r_spi_start  <= w_spi_start_n;
            r_spi_byte   <= w_spi_byte_n;
        end
    end

    // Next-state for the frame walker and the byte handshake
    always_comb begin
        w_state_n      = r_state;
        w_bh_n         = r_bh;
        w_led_cnt_n    = r_led_cnt;
        w_byte_cnt_n   = r_byte_cnt;
        w_bright_n     = r_bright;
        w_pix_n        = r_pix;
        w_fetch_wait_n = r_fetch_wait;
        w_frame_busy_n = r_frame_busy;
        w_frame_done_n = 1'b0;
        w_pix_addr_n   = r_pix_addr;
        w_spi_start_n  = r_spi_start;
        w_spi_byte_n   = r_spi_byte;
        w_byte_done_c  = 1'b0;

        w_send_c = r_state inside {S_SOF, S_HDR, S_BLU, S_GRN, S_RED, S_EOF};

        case (r_state)
            S_HDR:   w_tx_byte_c = {3'b111, r_bright};
            S_BLU:   w_tx_byte_c = r_pix[7:0];
            S_GRN:   w_tx_byte_c = r_pix[15:8];
            S_RED:   w_tx_byte_c = r_pix[23:16];
            S_EOF:   w_tx_byte_c = 8'hFF;
            default: w_tx_byte_c = 8'h00;
        endcase

        // Busy low while requesting means the writer has not taken the byte yet
        case (r_bh)
            BH_IDLE: begin
                if (w_send_c && !spi.spi_busy) begin
                    w_spi_byte_n  = w_tx_byte_c;
                    w_spi_start_n = 1'b1;
                    w_bh_n        = BH_REQ;
                end
            end
            BH_REQ: begin
                if (spi.spi_busy) begin
                    w_spi_start_n = 1'b0;
                    w_bh_n        = BH_ACK;
                end
            end
            BH_ACK: begin
                if (!spi.spi_busy) begin
                    w_byte_done_c = 1'b1;
                    w_bh_n        = BH_IDLE;
                end
            end
            default: w_bh_n = BH_IDLE;
        endcase

        case (r_state)
            S_IDLE: begin
                if (i_frame_start) begin
                    w_bright_n     = i_brightness;
                    w_frame_busy_n = 1'b1;
                    w_led_cnt_n    = '0;
                    w_byte_cnt_n   = '0;
                    w_pix_addr_n   = '0;
                    w_fetch_wait_n = 1'b0;
                    w_state_n      = (START_BYTES == 0) ? S_FETCH : S_SOF;
                end
            end
            S_SOF: begin
                if (w_byte_done_c) begin
                    if (r_byte_cnt == CNT_W'(START_BYTES - 1)) begin
                        w_byte_cnt_n = '0;
                        w_state_n    = S_FETCH;
                    end else begin
                        w_byte_cnt_n = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            // Address is already on the bus on entry; data is latched one cycle later
            S_FETCH: begin
                if (!r_fetch_wait) begin
                    w_fetch_wait_n = 1'b1;
                end else begin
                    w_fetch_wait_n = 1'b0;
                    w_pix_n        = i_pix_data;
                    w_state_n      = S_HDR;
                end
            end
            S_HDR: if (w_byte_done_c) w_state_n = S_BLU;
            S_BLU: if (w_byte_done_c) w_state_n = S_GRN;
            S_GRN: if (w_byte_done_c) w_state_n = S_RED;
            S_RED: begin
                if (w_byte_done_c) begin
                    if (r_led_cnt == ADDR_W'(NUM_LEDS - 1)) begin
                        w_byte_cnt_n = '0;
                        w_state_n    = S_EOF;
                    end else begin
                        w_led_cnt_n  = r_led_cnt + ADDR_W'(1);
                        w_pix_addr_n = r_led_cnt + ADDR_W'(1);
                        w_state_n    = S_FETCH;
                    end
                end
            end
            S_EOF: begin
                if (w_byte_done_c) begin
                    if (r_byte_cnt == CNT_W'(END_BYTES - 1)) begin
                        w_byte_cnt_n   = '0;
                        w_frame_busy_n = 1'b0;
                        w_frame_done_n = 1'b1;
                        w_state_n      = S_IDLE;
                    end else begin
                        w_byte_cnt_n = r_byte_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench: two sequencer instances (2 LEDs / 4 end bytes, 1 LED / 1 end byte)
// driven against a randomized byte-writer model and a frame-level reference.
module tb_led_frame_sequencer;

    logic        clk;
    logic        rst_n;
    logic        fs      [0:1];
    logic [4:0]  br      [0:1];
    logic        busy_o  [0:1];
    logic        done_o  [0:1];
    logic [1:0]  addr0;
    logic [0:0]  addr1;
    logic [23:0] pix0, pix1;
    logic [23:0] mem0 [0:3];
    logic [23:0] mem1 [0:1];
    logic [1:0]  a0;
    logic [0:0]  a1;

    logic        wr_busy  [0:1];
    logic        ext_busy [0:1];
    logic        w_start  [0:1];
    logic [7:0]  w_byte   [0:1];
    logic [7:0]  cap      [0:1][0:1023];
    int          cap_n    [0:1];
    int          done_n   [0:1];
    int          max_hold;
    logic [7:0]  exp_q [$];

    int total;
    int bad;

    led_frame_sequencer_if if0 ();
    led_frame_sequencer_if if1 ();

    assign if0.spi_busy = wr_busy[0] | ext_busy[0];
    assign if1.spi_busy = wr_busy[1] | ext_busy[1];
    assign w_start[0]   = if0.spi_start;
    assign w_start[1]   = if1.spi_start;
    assign w_byte[0]    = if0.spi_byte;
    assign w_byte[1]    = if1.spi_byte;

    led_frame_sequencer #(.NUM_LEDS(2), .ADDR_W(2), .START_BYTES(4), .END_BYTES(4)) u_dut0 (
        .i_spi_clk(clk), .i_reset_n(rst_n), .i_frame_start(fs[0]), .i_brightness(br[0]),
        .o_frame_busy(busy_o[0]), .o_frame_done(done_o[0]), .o_pix_addr(addr0),
        .i_pix_data(pix0), .spi(if0.master)
    );

    led_frame_sequencer #(.NUM_LEDS(1), .ADDR_W(1), .START_BYTES(4), .END_BYTES(1)) u_dut1 (
        .i_spi_clk(clk), .i_reset_n(rst_n), .i_frame_start(fs[1]), .i_brightness(br[1]),
        .o_frame_busy(busy_o[1]), .o_frame_done(done_o[1]), .o_pix_addr(addr1),
        .i_pix_data(pix1), .spi(if1.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous pixel memory: data for the address of one cycle appears after the next edge
    initial begin
        pix0 = '0;
        pix1 = '0;
        forever begin
            @(posedge clk);
            a0 = addr0;
            a1 = addr1;
            #1;
            pix0 = mem0[a0];
            pix1 = mem1[a1];
        end
    end

    initial begin
        done_n[0] = 0;
        done_n[1] = 0;
        forever begin
            @(negedge clk);
            if (done_o[0] === 1'b1) done_n[0]++;
            if (done_o[1] === 1'b1) done_n[1]++;
        end
    end

    // Byte writer: raises busy on start, captures the byte one cycle later, holds 1..max_hold cycles
    task automatic writer(input int k);
        int         left;
        logic [7:0] held;
        bit         in_ack;
        bit         spoiled;
        wr_busy[k] = 1'b0;
        left = 0;
        in_ack = 0;
        spoiled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!wr_busy[k]) begin
                if (w_start[k] === 1'b1) begin
                    wr_busy[k] = 1'b1;
                    left = int'($urandom_range(max_hold, 1));
                    in_ack = 0;
                    spoiled = 0;
                end
            end else begin
                if (!rst_n) spoiled = 1;
                if (!in_ack) begin
                    held = w_byte[k];
                    if (cap_n[k] < 1024) cap[k][cap_n[k]] = held;
                    cap_n[k]++;
                    in_ack = 1;
                end else if (!spoiled) begin
                    total++;
                    if (w_byte[k] !== held) begin
                        bad++;
                        $display("FAIL byte_stable[%0d] got %02h want %02h", k, w_byte[k], held);
                    end
                end
                if (!spoiled) begin
                    total++;
                    if (w_start[k] !== 1'b0) begin
                        bad++;
                        $display("FAIL start_in_ack[%0d] got %b want 0", k, w_start[k]);
                    end
                end
                left--;
                if (left <= 0) wr_busy[k] = 1'b0;
            end
        end
    endtask

    initial writer(0);
    initial writer(1);

    // Reference frame: start zeros, {111,b} B G R per LED, end 0xFF bytes
    function automatic void add_frame(input int k, input logic [4:0] b);
        int          nl;
        int          eb;
        logic [23:0] px;
        nl = (k == 0) ? 2 : 1;
        eb = (k == 0) ? 4 : 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        for (int l = 0; l < nl; l++) begin
            px = (k == 0) ? mem0[l] : mem1[l];
            exp_q.push_back({3'b111, b});
            exp_q.push_back(px[7:0]);
            exp_q.push_back(px[15:8]);
            exp_q.push_back(px[23:16]);
        end
        for (int i = 0; i < eb; i++) exp_q.push_back(8'hFF);
    endfunction

    task automatic pulse_start(input int k);
        @(negedge clk);
        fs[k] = 1'b1;
        @(negedge clk);
        fs[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o[k] === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total += 4;
            if (busy_o[k] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d] got %b want 0", k, busy_o[k]); end
            if (done_o[k] !== 1'b0) begin bad++; $display("FAIL rst_done[%0d] got %b want 0", k, done_o[k]); end
            if (w_start[k] !== 1'b0) begin bad++; $display("FAIL rst_start[%0d] got %b want 0", k, w_start[k]); end
            if (w_byte[k] !== 8'h00) begin bad++; $display("FAIL rst_byte[%0d] got %02h want 00", k, w_byte[k]); end
        end
        total += 2;
        if (addr0 !== 2'd0) begin bad++; $display("FAIL rst_addr0 got %0d want 0", addr0); end
        if (addr1 !== 1'd0) begin bad++; $display("FAIL rst_addr1 got %0d want 0", addr1); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        max_hold = 1;
        mem0[0] = 24'h112233;
        mem0[1] = 24'hAABBCC;
        br[0] = 5'h1F;
        cap_n[0] = 0;
        d0 = done_n[0];
        exp_q.delete();
        add_frame(0, 5'h1F);
        pulse_start(0);
        wait_done(0, 2000, ok);
        total += 2;
        if (!ok) begin bad++; $display("FAIL basic_timeout got no done want done"); end
        if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got %b want 0", busy_o[0]); end
        repeat (5) @(negedge clk);
        total += 2;
        if (cap_n[0] != exp_q.size()) begin bad++; $display("FAIL basic_len got %0d want %0d", cap_n[0], exp_q.size()); end
        if (done_n[0] - d0 != 1) begin bad++; $display("FAIL basic_done_cnt got %0d want 1", done_n[0] - d0); end
        for (int i = 0; i < exp_q.size() && i < cap_n[0]; i++) begin
            total++;
            if (cap[0][i] !== exp_q[i]) begin bad++; $display("FAIL basic_byte[%0d] got %02h want %02h", i, cap[0][i], exp_q[i]); end
        end
    endtask

    task automatic test_random_busy();
        bit         ok;
        logic [4:0] b;
        max_hold = 20;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) mem0[i] = 24'($urandom);
            b = 5'($urandom);
            br[0] = b;
            cap_n[0] = 0;
            exp_q.delete();
            add_frame(0, b);
            pulse_start(0);
            wait_done(0, 4000, ok);
            repeat (3) @(negedge clk);
            total += 2;
            if (!ok) begin bad++; $display("FAIL rand_timeout[%0d] got no done want done", f); end
            if (cap_n[0] != exp_q.size()) begin bad++; $display("FAIL rand_len[%0d] got %0d want %0d", f, cap_n[0], exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < cap_n[0]; i++) begin
                total++;
                if (cap[0][i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte[%0d] got %02h want %02h", i, cap[0][i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        bit         up;
        int         d0;
        logic [4:0] b [0:2];
        max_hold = 4;
        for (int i = 0; i < 4; i++) mem0[i] = 24'($urandom);
        for (int i = 0; i < 3; i++) b[i] = 5'($urandom);
        cap_n[0] = 0;
        d0 = done_n[0];
        exp_q.delete();
        for (int i = 0; i < 3; i++) add_frame(0, b[i]);
        @(negedge clk);
        br[0] = b[0];
        fs[0] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            up = 0;
            for (int i = 0; i < 50 && !up; i++) begin
                @(negedge clk);
                up = (busy_o[0] === 1'b1);
            end
            total++;
            if (!up) begin bad++; $display("FAIL b2b_accept[%0d] got idle want busy", f); end
            repeat (6) @(negedge clk);
            br[0] = (f < 2) ? b[f + 1] : 5'($urandom);
            wait_done(0, 2000, ok);
            if (f == 2) fs[0] = 1'b0;
            total++;
            if (!ok) begin bad++; $display("FAIL b2b_timeout[%0d] got no done want done", f); end
        end
        repeat (5) @(negedge clk);
        total += 3;
        if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL b2b_extra_frame got busy %b want 0", busy_o[0]); end
        if (done_n[0] - d0 != 3) begin bad++; $display("FAIL b2b_done_cnt got %0d want 3", done_n[0] - d0); end
        if (cap_n[0] != exp_q.size()) begin bad++; $display("FAIL b2b_len got %0d want %0d", cap_n[0], exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_n[0]; i++) begin
            total++;
            if (cap[0][i] !== exp_q[i]) begin bad++; $display("FAIL b2b_byte[%0d] got %02h want %02h", i, cap[0][i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit         ok;
        bit         hit;
        int         d0;
        logic [4:0] b;
        max_hold = 8;
        for (int i = 0; i < 4; i++) mem0[i] = 24'($urandom);
        br[0] = 5'($urandom);
        cap_n[0] = 0;
        pulse_start(0);
        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = (cap_n[0] >= 7);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rmf_reach_grn got %0d bytes want 7", cap_n[0]); end
        ext_busy[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        total += 5;
        if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL rmf_rst_busy got %b want 0", busy_o[0]); end
        if (done_o[0] !== 1'b0) begin bad++; $display("FAIL rmf_rst_done got %b want 0", done_o[0]); end
        if (w_start[0] !== 1'b0) begin bad++; $display("FAIL rmf_rst_start got %b want 0", w_start[0]); end
        if (w_byte[0] !== 8'h00) begin bad++; $display("FAIL rmf_rst_byte got %02h want 00", w_byte[0]); end
        if (addr0 !== 2'd0) begin bad++; $display("FAIL rmf_rst_addr got %0d want 0", addr0); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cap_n[0] = 0;
        d0 = done_n[0];
        b = 5'($urandom);
        br[0] = b;
        exp_q.delete();
        add_frame(0, b);
        pulse_start(0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (w_start[0] !== 1'b0) begin bad++; $display("FAIL rmf_start_while_busy[%0d] got %b want 0", i, w_start[0]); end
        end
        ext_busy[0] = 1'b0;
        wait_done(0, 2000, ok);
        repeat (3) @(negedge clk);
        total += 3;
        if (!ok) begin bad++; $display("FAIL rmf_timeout got no done want done"); end
        if (done_n[0] - d0 != 1) begin bad++; $display("FAIL rmf_done_cnt got %0d want 1", done_n[0] - d0); end
        if (cap_n[0] != exp_q.size()) begin bad++; $display("FAIL rmf_len got %0d want %0d", cap_n[0], exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_n[0]; i++) begin
            total++;
            if (cap[0][i] !== exp_q[i]) begin bad++; $display("FAIL rmf_byte[%0d] got %02h want %02h", i, cap[0][i], exp_q[i]); end
        end
    endtask

    task automatic test_ignore_start();
        bit ok;
        int d0;
        max_hold = 3;
        br[0] = 5'($urandom);
        cap_n[0] = 0;
        d0 = done_n[0];
        pulse_start(0);
        for (int p = 0; p < 4; p++) begin
            repeat (int'($urandom_range(8, 3))) @(negedge clk);
            total++;
            if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL ign_busy_during[%0d] got %b want 1", p, busy_o[0]); end
            fs[0] = 1'b1;
            @(negedge clk);
            fs[0] = 1'b0;
        end
        wait_done(0, 2000, ok);
        repeat (10) @(negedge clk);
        total += 4;
        if (!ok) begin bad++; $display("FAIL ign_timeout got no done want done"); end
        if (busy_o[0] !== 1'b0) begin bad++; $display("FAIL ign_requeued got busy %b want 0", busy_o[0]); end
        if (cap_n[0] != 16) begin bad++; $display("FAIL ign_len got %0d want 16", cap_n[0]); end
        if (done_n[0] - d0 != 1) begin bad++; $display("FAIL ign_done_cnt got %0d want 1", done_n[0] - d0); end
    endtask

    task automatic test_single_led();
        bit         ok;
        int         d1;
        logic [4:0] b;
        max_hold = 20;
        for (int f = 0; f < 2; f++) begin
            mem1[0] = 24'($urandom);
            mem1[1] = 24'($urandom);
            b = 5'($urandom);
            br[1] = b;
            cap_n[1] = 0;
            d1 = done_n[1];
            exp_q.delete();
            add_frame(1, b);
            pulse_start(1);
            wait_done(1, 2000, ok);
            total += 2;
            if (!ok) begin bad++; $display("FAIL one_timeout[%0d] got no done want done", f); end
            if (wr_busy[1] !== 1'b0) begin bad++; $display("FAIL one_done_early[%0d] got busy %b want 0", f, wr_busy[1]); end
            repeat (3) @(negedge clk);
            total += 2;
            if (cap_n[1] != 9) begin bad++; $display("FAIL one_len[%0d] got %0d want 9", f, cap_n[1]); end
            if (done_n[1] - d1 != 1) begin bad++; $display("FAIL one_done_cnt[%0d] got %0d want 1", f, done_n[1] - d1); end
            for (int i = 0; i < exp_q.size() && i < cap_n[1]; i++) begin
                total++;
                if (cap[1][i] !== exp_q[i]) begin bad++; $display("FAIL one_byte[%0d] got %02h want %02h", i, cap[1][i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        max_hold = 1;
        cap_n[0] = 0;
        cap_n[1] = 0;
        fs[0] = 1'b0;
        fs[1] = 1'b0;
        br[0] = '0;
        br[1] = '0;
        ext_busy[0] = 1'b0;
        ext_busy[1] = 1'b0;
        for (int i = 0; i < 4; i++) mem0[i] = '0;
        for (int i = 0; i < 2; i++) mem1[i] = '0;
        test_reset();
        test_basic();
        test_random_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignore_start();
        test_single_led();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
